// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA 640x480@60 timing generator with DCM-lock gated start-up
//
// Purpose:
//   Produces hsync/vsync, pixel coordinates, a visible-area flag and a
//   per-frame start pulse for the pixel renderer. The raster is held at
//   (0,0) with the display blanked until the DCM lock has been brought
//   into the pixel clock domain; losing lock drops straight back to idle.
//
// Ports:
//   i_clk25        pixel clock (25 MHz from the DCM stage)
//   i_rst_n        asynchronous active-low reset
//   i_dcm_lock     DCM lock, asynchronous to i_clk25 during start-up
//   o_locked       i_dcm_lock after a 2-flop synchronizer
//   o_hsync        horizontal sync, asserted level = SYNC_POL
//   o_vsync        vertical sync, asserted level = SYNC_POL
//   o_video_on     high while (o_pix_x, o_pix_y) is in the visible area
//   o_pix_x        horizontal position, 0..H_TOTAL-1
//   o_pix_y        vertical position, 0..V_TOTAL-1
//   o_frame_start  one-cycle pulse at (0,0) of every running frame
//
// Both totals must fit the 10-bit counters (at most 1024).

module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       i_clk25,
  input  logic       i_rst_n,
  input  logic       i_dcm_lock,
  output logic       o_locked,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_video_on,
  output logic [9:0] o_pix_x,
  output logic [9:0] o_pix_y,
  output logic       o_frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic       lock_meta_q;
  logic       lock_sync_q;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;
  logic       run_d;

  // Next raster position. The decodes below are taken from this next
  // position so that every registered output describes the same pixel as
  // the registered counters in the same cycle.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;

    if (!lock_sync_q) begin
      // Lock lost (or not yet seen): abandon the frame, no partial pulses.
      state_d = ST_IDLE;
      x_d     = '0;
      y_d     = '0;
    end else if (state_q == ST_IDLE) begin
      // First running cycle shows (0,0); a relock never resumes mid-frame.
      state_d = ST_RUN;
      x_d     = '0;
      y_d     = '0;
    end else if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end else begin
      x_d = x_q + 10'd1;
    end

    run_d         = (state_d == ST_RUN);
    hsync_d       = (run_d && (x_d >= HS_START) && (x_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (run_d && (y_d >= VS_START) && (y_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = run_d && (x_d < H_VIS_END) && (y_d < V_VIS_END);
    frame_start_d = run_d && (x_d == 10'd0) && (y_d == 10'd0);
  end

  always_ff @(posedge i_clk25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_meta_q   <= 1'b0;
      lock_sync_q   <= 1'b0;
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      lock_meta_q   <= i_dcm_lock;
      lock_sync_q   <= lock_meta_q;
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_locked      = lock_sync_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_video_on    = video_on_q;
  assign o_pix_x       = x_q;
  assign o_pix_y       = y_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen on a reduced raster

module tb_vga_sync_gen;

  // Reduced raster keeps a full frame short; the reference model uses the
  // same numbers, so the timing rules are exercised at their boundaries.
  localparam int HV = 64;
  localparam int HF = 4;
  localparam int HSY = 12;
  localparam int HB = 8;
  localparam int VV = 40;
  localparam int VF = 3;
  localparam int VSY = 2;
  localparam int VB = 5;
  localparam bit SP = 1'b0;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;
  localparam int FRAME = HT * VT;
  localparam int HS0 = HV + HF;
  localparam int VS0 = VV + VF;
  localparam logic [24:0] IDLE_VEC = {1'b0, ~SP, ~SP, 1'b0, 1'b0, 20'd0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock;
  logic       o_locked, o_hsync, o_vsync, o_video_on, o_frame_start;
  logic [9:0] o_pix_x, o_pix_y;

  int checks = 0;
  int failures = 0;

  vga_sync_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .SYNC_POL(SP)
  ) dut (
    .i_clk25      (clk),
    .i_rst_n      (rst_n),
    .i_dcm_lock   (lock),
    .o_locked     (o_locked),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_video_on   (o_video_on),
    .o_pix_x      (o_pix_x),
    .o_pix_y      (o_pix_y),
    .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  wire logic [24:0] dut_vec = {o_locked, o_hsync, o_vsync, o_video_on, o_frame_start, o_pix_x, o_pix_y};

  // Reference model: lock history plus the number of edges the raster has
  // been running; position is derived from that count arithmetically.
  logic [1:0] m_sync;
  int         run_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync <= 2'b00;
      run_n  <= 0;
    end else begin
      m_sync <= {m_sync[0], lock};
      run_n  <= m_sync[1] ? run_n + 1 : 0;
    end
  end

  function automatic logic [24:0] model_vec();
    int p, ex, ey;
    logic hs, vs, von, fs;
    if (run_n == 0) return {m_sync[1], ~SP, ~SP, 1'b0, 1'b0, 20'd0};
    p   = run_n - 1;
    ex  = p % HT;
    ey  = (p / HT) % VT;
    hs  = (ex >= HS0 && ex < HS0 + HSY) ? SP : ~SP;
    vs  = (ey >= VS0 && ey < VS0 + VSY) ? SP : ~SP;
    von = (ex < HV) && (ey < VV);
    fs  = (ex == 0) && (ey == 0);
    return {m_sync[1], hs, vs, von, fs, 10'(ex), 10'(ey)};
  endfunction

  task automatic wait_pos(input int tx, input int ty, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (o_pix_x == 10'(tx) && o_pix_y == 10'(ty)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lock  = 1'b0;
    repeat (100) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== IDLE_VEC) begin
        failures++;
        $display("FAIL reset_idle: got %h expected %h", dut_vec, IDLE_VEC);
      end
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== IDLE_VEC) begin
        failures++;
        $display("FAIL idle_unlocked: got %h expected %h", dut_vec, IDLE_VEC);
      end
    end
  endtask

  task automatic test_start_and_frame();
    int hs_cnt, hs_first, vs_cnt, vs_fx, vs_fy, von_cnt, fs_cnt, lines;
    hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_fx = -1; vs_fy = -1;
    von_cnt = 0; fs_cnt = 0; lines = 0;
    lock = 1'b1;
    @(negedge clk);
    checks++;
    if (o_locked !== 1'b0) begin
      failures++;
      $display("FAIL lock_edge_k: got locked=%b expected 0", o_locked);
    end
    @(negedge clk);
    checks++;
    if (o_locked !== 1'b1 || o_frame_start !== 1'b0) begin
      failures++;
      $display("FAIL lock_edge_k1: got locked=%b fs=%b expected 1 0", o_locked, o_frame_start);
    end
    @(negedge clk);
    checks++;
    if ({o_pix_x, o_pix_y, o_frame_start, o_video_on} !== {20'd0, 2'b11}) begin
      failures++;
      $display("FAIL first_run: got x=%0d y=%0d fs=%b von=%b expected 0 0 1 1",
               o_pix_x, o_pix_y, o_frame_start, o_video_on);
    end
    for (int n = 0; n < FRAME; n++) begin
      if (n > 0) @(negedge clk);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL frame_track n=%0d: got %h expected %h", n, dut_vec, model_vec());
      end
      if (o_hsync == SP) begin
        if (hs_cnt == 0) hs_first = int'(o_pix_x);
        hs_cnt++;
      end
      if (o_vsync == SP) begin
        if (vs_cnt == 0) begin
          vs_fx = int'(o_pix_x);
          vs_fy = int'(o_pix_y);
        end
        vs_cnt++;
      end
      if (o_video_on) von_cnt++;
      if (o_frame_start) fs_cnt++;
      if (o_pix_x == 10'(HT - 1)) begin
        checks++;
        if (hs_cnt != HSY || hs_first != HS0) begin
          failures++;
          $display("FAIL hsync_line y=%0d: got count=%0d first=%0d expected %0d %0d",
                   o_pix_y, hs_cnt, hs_first, HSY, HS0);
        end
        hs_cnt = 0;
        hs_first = -1;
        lines++;
      end
    end
    checks++;
    if (lines != VT) begin
      failures++;
      $display("FAIL line_count: got %0d expected %0d", lines, VT);
    end
    checks++;
    if (vs_cnt != VSY * HT || vs_fx != 0 || vs_fy != VS0) begin
      failures++;
      $display("FAIL vsync_frame: got count=%0d at (%0d,%0d) expected %0d at (0,%0d)",
               vs_cnt, vs_fx, vs_fy, VSY * HT, VS0);
    end
    checks++;
    if (von_cnt != HV * VV) begin
      failures++;
      $display("FAIL video_on_count: got %0d expected %0d", von_cnt, HV * VV);
    end
    checks++;
    if (fs_cnt != 1) begin
      failures++;
      $display("FAIL frame_start_count: got %0d expected 1", fs_cnt);
    end
    @(negedge clk);
    checks++;
    if (o_frame_start !== 1'b1 || o_pix_x !== 10'd0 || o_pix_y !== 10'd0) begin
      failures++;
      $display("FAIL frame_period: got fs=%b x=%0d y=%0d expected 1 0 0",
               o_frame_start, o_pix_x, o_pix_y);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    wait_pos(HT - 1, VT - 1, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wrap_reach: got timeout expected x=%0d y=%0d", HT - 1, VT - 1);
    end
    @(negedge clk);
    checks++;
    if ({o_pix_x, o_pix_y, o_frame_start, o_vsync, o_video_on} !== {20'd0, 1'b1, ~SP, 1'b1}) begin
      failures++;
      $display("FAIL wrap: got x=%0d y=%0d fs=%b vs=%b von=%b expected 0 0 1 %b 1",
               o_pix_x, o_pix_y, o_frame_start, o_vsync, o_video_on, ~SP);
    end
  endtask

  task automatic test_lock_loss();
    bit ok;
    int tx, ty, idle_n;
    for (int it = 0; it < 3; it++) begin
      tx = int'($urandom_range(HS0, HS0 + HSY - 3));
      ty = (it == 0) ? 30 : int'($urandom_range(0, VT - 1));
      wait_pos(tx, ty, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL loss_reach: got timeout expected x=%0d y=%0d", tx, ty);
      end
      lock = 1'b0;
      @(negedge clk);
      checks++;
      if (o_locked !== 1'b1 || o_pix_x !== 10'(tx + 1) || o_hsync !== SP) begin
        failures++;
        $display("FAIL loss_m: got locked=%b x=%0d hs=%b expected 1 %0d %b",
                 o_locked, o_pix_x, o_hsync, tx + 1, SP);
      end
      @(negedge clk);
      checks++;
      if (o_locked !== 1'b0 || o_pix_x !== 10'(tx + 2) || o_hsync !== SP) begin
        failures++;
        $display("FAIL loss_m1: got locked=%b x=%0d hs=%b expected 0 %0d %b",
                 o_locked, o_pix_x, o_hsync, tx + 2, SP);
      end
      idle_n = int'($urandom_range(2, 10));
      for (int c = 0; c < idle_n; c++) begin
        @(negedge clk);
        checks++;
        if (dut_vec !== IDLE_VEC) begin
          failures++;
          $display("FAIL loss_idle c=%0d: got %h expected %h", c, dut_vec, IDLE_VEC);
        end
      end
      lock = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({o_locked, o_pix_x, o_pix_y, o_frame_start} !== {1'b1, 20'd0, 1'b1}) begin
        failures++;
        $display("FAIL relock: got locked=%b x=%0d y=%0d fs=%b expected 1 0 0 1",
                 o_locked, o_pix_x, o_pix_y, o_frame_start);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_pos(20, VS0 + VSY - 1, ok);
    checks++;
    if (!ok || o_vsync !== SP) begin
      failures++;
      $display("FAIL rstmid_reach: got ok=%b vs=%b expected 1 %b", ok, o_vsync, SP);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== IDLE_VEC) begin
      failures++;
      $display("FAIL rstmid_async: got %h expected %h", dut_vec, IDLE_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_locked !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_e1: got locked=%b expected 0", o_locked);
    end
    @(negedge clk);
    checks++;
    if (o_locked !== 1'b1 || o_frame_start !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_e2: got locked=%b fs=%b expected 1 0", o_locked, o_frame_start);
    end
    @(negedge clk);
    checks++;
    if ({o_pix_x, o_pix_y, o_frame_start, o_video_on} !== {20'd0, 2'b11}) begin
      failures++;
      $display("FAIL rstmid_run: got x=%0d y=%0d fs=%b von=%b expected 0 0 1 1",
               o_pix_x, o_pix_y, o_frame_start, o_video_on);
    end
  endtask

  task automatic test_random_lock();
    lock = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++;
        $display("FAIL random_track n=%0d: got %h expected %h", n, dut_vec, model_vec());
      end
      if (lock && $urandom_range(0, 299) == 0) lock = 1'b0;
      else if (!lock && $urandom_range(0, 3) == 0) lock = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lock  = 1'b0;
    test_reset();
    test_start_and_frame();
    test_wrap();
    test_lock_loss();
    test_reset_mid();
    test_random_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
